// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling and a one-byte output holding register
// Optional macro UART_RX_MAJORITY_EN: data/stop bits voted 2-of-3 over counter 13, 14, 15.
module uart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       i_rx_en,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        FRERR = 3'd4
    } state_t;

    state_t      state, state_d;
    logic        rx_s1, rx_s2;
    logic [3:0]  cnt, cnt_d;
    logic [2:0]  idx, idx_d;
    logic [7:0]  shreg, shreg_d;
    logic [7:0]  data_d;
    logic        valid_d, ferr_d, ovr_d;
    logic        bit_val;

`ifdef UART_RX_MAJORITY_EN
    logic samp13, samp14;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp13 <= 1'b1;
            samp14 <= 1'b1;
        end else if (tick && (state == DATA || state == STOP)) begin
            if (cnt == 4'd13) samp13 <= rx_s2;
            if (cnt == 4'd14) samp14 <= rx_s2;
        end
    end

    // The third vote is the live sample taken at counter 15.
    assign bit_val = (samp13 & samp14) | (samp13 & rx_s2) | (samp14 & rx_s2);
`else
    assign bit_val = rx_s2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            state       <= IDLE;
            cnt         <= 4'd0;
            idx         <= 3'd0;
            shreg       <= 8'h00;
            o_data      <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            rx_s1       <= i_rx;
            rx_s2       <= rx_s1;
            state       <= state_d;
            cnt         <= cnt_d;
            idx         <= idx_d;
            shreg       <= shreg_d;
            o_data      <= data_d;
            o_valid     <= valid_d;
            o_frame_err <= ferr_d;
            o_overrun   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        shreg_d = shreg;
        data_d  = o_data;
        valid_d = o_valid & ~i_ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (!i_rx_en) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            idx_d   = 3'd0;
            valid_d = 1'b0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s2) begin
                        state_d = START;
                        cnt_d   = 4'd0;
                    end
                end
                START: begin
                    if (cnt == 4'd7) begin
                        // Start bit re-checked mid-bit; a short low pulse is dropped silently.
                        state_d = rx_s2 ? IDLE : DATA;
                        cnt_d   = 4'd0;
                        idx_d   = 3'd0;
                    end else begin
                        cnt_d = cnt + 4'd1;
                    end
                end
                DATA: begin
                    cnt_d = cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        shreg_d = {bit_val, shreg[7:1]};
                        if (idx == 3'd7) state_d = STOP;
                        else             idx_d   = idx + 3'd1;
                    end
                end
                STOP: begin
                    cnt_d = cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        if (bit_val) begin
                            state_d = IDLE;
                            if (!o_valid || i_ready) begin
                                data_d  = shreg;
                                valid_d = 1'b1;
                            end else begin
                                ovr_d = 1'b1;
                            end
                        end else begin
                            state_d = FRERR;
                            ferr_d  = 1'b1;
                        end
                    end
                end
                FRERR: begin
                    // Wait for the line to go idle so a held break does not retrigger.
                    if (rx_s2) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    idx_d   = 3'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
Parameters:
REQ-001 SHALL have no parameters; frame fixed at 8N1 (1 start, 8 data LSB first, 1 stop); oversampling fixed at 16 ticks per bit.
Ports:
REQ-002 SHALL provide: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL provide: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide: tick  input  1  one-clk strobe at 16x baud rate.
REQ-005 SHALL provide: i_rx_en  input  1  receiver enable; low = synchronous clear.
REQ-006 SHALL provide: i_rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL provide: o_data  output  8  received byte, stable while o_valid high.
REQ-008 SHALL provide: o_valid  output  1  byte available.
REQ-009 SHALL provide: i_ready  input  1  consumer accepts byte when o_valid & i_ready.
REQ-010 SHALL provide: o_frame_err  output  1  one-clk pulse, stop bit sampled low.
REQ-011 SHALL provide: o_overrun  output  1  one-clk pulse, byte lost because o_valid still high.

Function
REQ-012 i_rx SHALL pass a 2-flop synchronizer, both flops reset to 1; all sampling uses the synchronized value.
REQ-013 SHALL implement states IDLE, START, DATA, STOP with a 4-bit tick counter and a 3-bit bit index.
REQ-014 IDLE: on tick with synchronized line 0 -> START, counter = 0.
REQ-015 START: counter advances on tick; at counter == 7, line 0 -> DATA with counter = 0 and index = 0; line 1 -> IDLE (glitch rejected, no flags).
REQ-016 DATA: counter advances on tick; at counter == 15 the bit is sampled into a shift register LSB first; after index 7 -> STOP, else index + 1.
REQ-017 STOP: at counter == 15, sample 1 -> valid frame; sample 0 -> o_frame_err pulse, byte discarded, state FRERR.
REQ-018 FRERR: SHALL remain until a tick sees the synchronized line 1, then -> IDLE (no break-condition retriggering).
REQ-019 Valid frame with o_valid == 0, or with o_valid & i_ready in the same cycle: o_data <= shifted byte, o_valid <= 1, visible the clk after the stop sample.
REQ-020 Valid frame with o_valid high and i_ready low: o_data unchanged, o_overrun pulses one clk, new byte dropped.
REQ-021 o_valid SHALL clear the clk after o_valid & i_ready, unless REQ-019 reloads it in that cycle.
REQ-022 After a valid frame the state SHALL return to IDLE on the same edge; back-to-back frames SHALL be received with no idle gap.
REQ-023 i_rx_en low SHALL force IDLE, counters 0, o_valid 0, both flags 0 on the next edge; o_data holds its value.
REQ-024 The state machine SHALL advance only on clocks where tick is high; REQ-015 to REQ-018 and REQ-020 apply only on such clocks.

Reset
REQ-025 rst high SHALL asynchronously set state IDLE, counters 0, shift register 0, o_data 0x00, o_valid 0, o_frame_err 0, o_overrun 0, and synchronizer flops 1.
REQ-026 rst asserted mid-frame SHALL discard the partial byte; after release the receiver waits for a fresh falling edge.

Configuration
REQ-027 Macro UART_RX_MAJORITY_EN defined: each data and stop bit SHALL be the 2-of-3 majority of line samples at counter 13, 14, 15.
REQ-028 Macro UART_RX_MAJORITY_EN undefined: each bit SHALL be the single sample at counter 15; no sample registers are built.
REQ-029 The start-bit check (REQ-015) SHALL use a single sample in both builds.

Verification
REQ-030 Send frame 0xA5, i_ready held 1 -> o_data = 0xA5, o_valid high for 1 clk, no flags.
REQ-031 Drive i_rx low for 4 ticks then high -> receiver returns to IDLE; o_valid and flags stay 0.
REQ-032 Send 0x3C with stop bit 0 -> o_frame_err pulses once, o_valid stays 0; line high, then 0x55 -> 0x55 received.
REQ-033 Send 0x11 then 0x22 back-to-back, i_ready 0 -> o_data = 0x11 held, o_overrun pulses once after second stop.
REQ-034 Assert rst at data bit 4 of 0xFF, release, send 0x0F -> only 0x0F delivered.
REQ-035 With UART_RX_MAJORITY_EN defined, send 0x81 with i_rx inverted at counter 14 of every bit -> 0x81 received; undefined build, glitch at counter 15 -> corrupted byte.
